ex_result_merge_pipe: RTL
=========================

Name: ex_result_merge_pipe

Overview:
- Parametrised merge point where single-cycle and multi-cycle execute results join before the memory access stage.
- Tracks multi-cycle instruction metadata through a delay line of configurable latency.
- Resolves the single/multi-cycle writeback collision in hardware with a one-entry skid buffer and an upstream stall, rather than relying on the strand scheduler.
- Supports per-strand selective flush and coalesces comparison results into a lane bitmask.

Parameters:
- NUM_LANES, 16, vector lanes.
- LANE_WIDTH, 32, bits per lane.
- MC_LATENCY, 3, cycles from multi-cycle issue to result valid (range 1..8).
- NUM_STRANDS, 4, hardware strands.
- REG_IDX_WIDTH, 7, writeback register index width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- sc_valid  in  1  single-cycle result present this cycle.
- sc_strand  in  log2(NUM_STRANDS)  strand of the single-cycle op.
- sc_pc, sc_instruction  in  32 each  PC and instruction word.
- sc_has_writeback, sc_writeback_is_vector  in  1 each  writeback control.
- sc_writeback_reg  in  REG_IDX_WIDTH  destination register.
- sc_mask  in  NUM_LANES  lane write mask.
- sc_is_compare  in  1  result requires coalescing.
- sc_result  in  NUM_LANES*LANE_WIDTH  single-cycle ALU result.
- mc_issue_valid  in  1  multi-cycle op issued this cycle.
- mc_strand, mc_pc, mc_instruction, mc_has_writeback, mc_writeback_is_vector, mc_writeback_reg, mc_mask, mc_is_compare  in  as sc_*  metadata of the issued op.
- mc_result  in  NUM_LANES*LANE_WIDTH  multi-cycle ALU result, valid exactly MC_LATENCY cycles after issue.
- flush_strand_mask  in  NUM_STRANDS  kill all in-flight work of the flagged strands.
- ex_stall  out  1  upstream must not present sc_valid or mc_issue_valid.
- ex_valid, ex_strand, ex_pc, ex_instruction, ex_has_writeback, ex_writeback_is_vector, ex_writeback_reg, ex_mask  out  as above  registered outputs to the memory access stage.
- ex_result  out  NUM_LANES*LANE_WIDTH  registered result.

Behaviour:
- Reset: every output register is 0, ex_stall is 0, delay-line valid bits are 0, skid buffer is empty. Reset is asynchronous and may assert mid-operation; all in-flight entries are discarded.
- Delay line: MC_LATENCY stages. Stage 0 loads the mc_* metadata when mc_issue_valid is 1, otherwise a bubble. The last stage is the "completion" and pairs with mc_result in that cycle.
- Each cycle, exactly one source is selected into the output registers, by priority:
  1. completion
  2. skid entry
  3. sc input
  4. bubble (ex_valid = 0, ex_has_writeback = 0, other fields 0).
- Collision, when completion is valid and sc_valid is 1:
  - sc is captured (metadata plus result) into the skid buffer.
  - If a skid entry and a completion coincide, the skid entry is held.
- ex_stall = skid_valid (combinational from the register).
- Skid drains in the first cycle with no valid completion.
- Protocol error: sc_valid or mc_issue_valid while ex_stall is 1. Simulation asserts; the hardware drops the input.
- Flush: flush_strand_mask[s] in cycle T causes the following, all to bubbles:
  - delay-line entries with strand s;
  - the skid entry if its strand is s;
  - same-cycle sc/mc inputs of strand s;
  - a selected source of strand s.
  Flush and new issue of another strand in the same cycle proceed normally. A flushed skid frees in that cycle, and ex_stall drops in T+1.
- Coalescing: when the selected source has is_compare set, ex_result[NUM_LANES-1:0] = bit 0 of each lane (lane i maps to bit i) and all upper bits are 0. Otherwise the result passes unchanged.
- Latency:
  - sc to ex_*: 1 cycle, or 2 or more if skidded.
  - mc issue to ex_*: MC_LATENCY+1 cycles.
- Ordering within a strand is preserved, since the scheduler never interleaves one strand's sc behind its own mc.

Optional Feature:
- EX_MERGE_PERF_COUNTERS_EN defined: adds outputs perf_collision_count (32) and perf_stall_cycles (32).
  - Both are saturating at 32'hFFFFFFFF.
  - Both reset to 0.
  - The collision counter increments on each skid capture; the stall counter increments on each cycle ex_stall is 1.
- Undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package ex_pkg holds:
  - the ex_meta_t typedef (strand, pc, instruction, writeback fields, mask, is_compare, valid);
  - the NOP constant;
  - the strand-index width function.
- Sub-module ex_latency_shift: a parametrised MC_LATENCY-deep ex_meta_t delay line with a per-strand kill input. The skid buffer and output mux live in the top module.

Test Plan:
- Isolated sc: sc_valid with pc=0x100 and result lane0=5 at T -> ex_valid=1, ex_pc=0x100, ex_result[31:0]=5 at T+1, ex_stall stays 0.
- Isolated mc (MC_LATENCY=3): issue pc=0x200 at T, mc_result=0xAA.. at T+3 -> ex_pc=0x200 at T+4. Cycles T+1..T+3 output bubbles.
- Collision: mc issue at T, sc pc=0x300 at T+3:
  - T+4: ex_pc=mc pc, ex_stall=1.
  - T+5: ex_pc=0x300, ex_stall=0.
  - T+6: ex_stall=0.
- Selective flush: mc strand 1 and strand 2 in flight, flush_strand_mask=4'b0010 -> the strand-1 completion emerges as a bubble and the strand-2 completion is delivered intact.
- Compare coalesce: sc_is_compare with lanes alternating 1/0 (lane0=1) -> ex_result[15:0]=16'h5555, upper bits 0.
- Reset mid-flight: assert reset_n=0 with skid full and 2 mc in flight -> all outputs and ex_stall 0 immediately; no ex_valid after release.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared types for the execute result merge point.
//   ex_meta_t     : per-instruction metadata carried alongside a result
//   EX_NOP        : all-zero metadata (a bubble)
//   strand_idx_w  : width of a strand index for a given strand count
//   strand_hit    : true when a strand index is flagged in a strand mask
// The struct is sized by the EX_* localparams below; the merge top's
// NUM_LANES / NUM_STRANDS / REG_IDX_WIDTH must be built with matching values.
package ex_pkg;

  function automatic int strand_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int EX_NUM_LANES     = 16;
  localparam int EX_NUM_STRANDS   = 4;
  localparam int EX_REG_IDX_WIDTH = 7;
  localparam int EX_STRAND_W      = strand_idx_w(EX_NUM_STRANDS);

  typedef struct packed {
    logic                        valid;
    logic [EX_STRAND_W-1:0]      strand;
    logic [31:0]                 pc;
    logic [31:0]                 instruction;
    logic                        has_writeback;
    logic                        writeback_is_vector;
    logic [EX_REG_IDX_WIDTH-1:0] writeback_reg;
    logic [EX_NUM_LANES-1:0]     mask;
    logic                        is_compare;
  } ex_meta_t;

  localparam ex_meta_t EX_NOP = '0;

  // Loop compare instead of a direct index so non power-of-two strand
  // counts never read past the end of the mask.
  function automatic logic strand_hit(input logic [EX_STRAND_W-1:0]    s,
                                      input logic [EX_NUM_STRANDS-1:0] m);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < EX_NUM_STRANDS; i++)
      if (m[i] && (s == EX_STRAND_W'(i))) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/ex_latency_shift.sv
// ex_latency_shift: MC_LATENCY-deep delay line of multi-cycle metadata.
//   clk, reset_n : clock, async active-low reset (clears all stages)
//   in_meta      : metadata entering stage 0 (valid=0 is a bubble)
//   kill_mask    : per-strand kill; matching entries (including in_meta)
//                  become bubbles as they advance
//   out_meta     : last stage, the completion that pairs with mc_result
module ex_latency_shift
  import ex_pkg::*;
#(
  parameter int MC_LATENCY  = 3,
  parameter int NUM_STRANDS = EX_NUM_STRANDS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  ex_meta_t               in_meta,
  input  logic [NUM_STRANDS-1:0] kill_mask,
  output ex_meta_t               out_meta
);

  ex_meta_t stg [MC_LATENCY];

  function automatic ex_meta_t scrub(input ex_meta_t m, input logic [NUM_STRANDS-1:0] k);
    return (m.valid && strand_hit(m.strand, k)) ? EX_NOP : m;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MC_LATENCY; i++) stg[i] <= EX_NOP;
    end else begin
      stg[0] <= scrub(in_meta, kill_mask);
      for (int i = 1; i < MC_LATENCY; i++) stg[i] <= scrub(stg[i-1], kill_mask);
    end
  end

  assign out_meta = stg[MC_LATENCY-1];

endmodule

// File: rtl/ex_result_merge_pipe.sv
// ex_result_merge_pipe: joins single-cycle (sc_*) and multi-cycle (mc_*)
// execute results into one registered stream for the memory stage.
//   clk, reset_n        : clock, async active-low reset
//   sc_*                : single-cycle result + metadata (sc_valid qualifies)
//   mc_issue_valid/mc_* : multi-cycle issue metadata; mc_result arrives
//                         MC_LATENCY cycles after issue
//   flush_strand_mask   : kill all in-flight work of flagged strands
//   ex_stall            : upstream must hold sc/mc issue (skid occupied)
//   ex_*                : registered output to the memory access stage
// Source priority each cycle: completion > skid entry > sc input > bubble.
// A completion colliding with sc parks sc in a one-entry skid buffer.
// Build option EX_MERGE_PERF_COUNTERS_EN adds saturating counters
// perf_collision_count (skid captures) and perf_stall_cycles.
module ex_result_merge_pipe
  import ex_pkg::*;
#(
  parameter int NUM_LANES     = EX_NUM_LANES,
  parameter int LANE_WIDTH    = 32,
  parameter int MC_LATENCY    = 3,
  parameter int NUM_STRANDS   = EX_NUM_STRANDS,
  parameter int REG_IDX_WIDTH = EX_REG_IDX_WIDTH,
  localparam int SW = strand_idx_w(NUM_STRANDS),
  localparam int RW = NUM_LANES * LANE_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sc_valid,
  input  logic [SW-1:0]            sc_strand,
  input  logic [31:0]              sc_pc,
  input  logic [31:0]              sc_instruction,
  input  logic                     sc_has_writeback,
  input  logic                     sc_writeback_is_vector,
  input  logic [REG_IDX_WIDTH-1:0] sc_writeback_reg,
  input  logic [NUM_LANES-1:0]     sc_mask,
  input  logic                     sc_is_compare,
  input  logic [RW-1:0]            sc_result,
  input  logic                     mc_issue_valid,
  input  logic [SW-1:0]            mc_strand,
  input  logic [31:0]              mc_pc,
  input  logic [31:0]              mc_instruction,
  input  logic                     mc_has_writeback,
  input  logic                     mc_writeback_is_vector,
  input  logic [REG_IDX_WIDTH-1:0] mc_writeback_reg,
  input  logic [NUM_LANES-1:0]     mc_mask,
  input  logic                     mc_is_compare,
  input  logic [RW-1:0]            mc_result,
  input  logic [NUM_STRANDS-1:0]   flush_strand_mask,
  output logic                     ex_stall,
  output logic                     ex_valid,
  output logic [SW-1:0]            ex_strand,
  output logic [31:0]              ex_pc,
  output logic [31:0]              ex_instruction,
  output logic                     ex_has_writeback,
  output logic                     ex_writeback_is_vector,
  output logic [REG_IDX_WIDTH-1:0] ex_writeback_reg,
  output logic [NUM_LANES-1:0]     ex_mask,
  output logic [RW-1:0]            ex_result
`ifdef EX_MERGE_PERF_COUNTERS_EN
  ,
  output logic [31:0]              perf_collision_count,
  output logic [31:0]              perf_stall_cycles
`endif
);

  ex_meta_t        sc_meta, mc_meta, comp_meta, skid_meta, sel_meta, out_q;
  logic [RW-1:0]   skid_result, sel_result, res_d, res_q;
  logic            skid_valid;
  logic            sc_live, comp_live, skid_live, capture;

  // Inputs arriving while stalled are protocol errors and are dropped.
  always_comb begin
    sc_meta                     = EX_NOP;
    sc_meta.valid               = sc_valid && !skid_valid;
    sc_meta.strand              = sc_strand;
    sc_meta.pc                  = sc_pc;
    sc_meta.instruction         = sc_instruction;
    sc_meta.has_writeback       = sc_has_writeback;
    sc_meta.writeback_is_vector = sc_writeback_is_vector;
    sc_meta.writeback_reg       = sc_writeback_reg;
    sc_meta.mask                = sc_mask;
    sc_meta.is_compare          = sc_is_compare;
    mc_meta                     = EX_NOP;
    mc_meta.valid               = mc_issue_valid && !skid_valid;
    mc_meta.strand              = mc_strand;
    mc_meta.pc                  = mc_pc;
    mc_meta.instruction         = mc_instruction;
    mc_meta.has_writeback       = mc_has_writeback;
    mc_meta.writeback_is_vector = mc_writeback_is_vector;
    mc_meta.writeback_reg       = mc_writeback_reg;
    mc_meta.mask                = mc_mask;
    mc_meta.is_compare          = mc_is_compare;
  end

  ex_latency_shift #(
    .MC_LATENCY  (MC_LATENCY),
    .NUM_STRANDS (NUM_STRANDS)
  ) u_shift (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_meta   (mc_meta),
    .kill_mask (flush_strand_mask),
    .out_meta  (comp_meta)
  );

  // Flushed sources are removed before selection so a lower-priority
  // source of another strand can use the slot.
  assign sc_live   = sc_meta.valid && !strand_hit(sc_meta.strand, flush_strand_mask);
  assign comp_live = comp_meta.valid && !strand_hit(comp_meta.strand, flush_strand_mask);
  assign skid_live = skid_valid && !strand_hit(skid_meta.strand, flush_strand_mask);
  assign capture   = comp_live && sc_live;

  always_comb begin
    sel_meta   = EX_NOP;
    sel_result = '0;
    if (comp_live) begin
      sel_meta   = comp_meta;
      sel_result = mc_result;
    end else if (skid_live) begin
      sel_meta   = skid_meta;
      sel_result = skid_result;
    end else if (sc_live) begin
      sel_meta   = sc_meta;
      sel_result = sc_result;
    end
  end

  // Compare results collapse to one bit per lane (lane bit 0).
  always_comb begin
    res_d = sel_result;
    if (sel_meta.is_compare) begin
      res_d = '0;
      for (int i = 0; i < NUM_LANES; i++) res_d[i] = sel_result[i*LANE_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q       <= EX_NOP;
      res_q       <= '0;
      skid_valid  <= 1'b0;
      skid_meta   <= EX_NOP;
      skid_result <= '0;
    end else begin
      out_q <= sel_meta;
      res_q <= res_d;
      if (capture) begin
        skid_valid  <= 1'b1;
        skid_meta   <= sc_meta;
        skid_result <= sc_result;
      end else if (!(skid_live && comp_live)) begin
        // drained this cycle, flushed, or already empty
        skid_valid <= 1'b0;
      end
    end
  end

  assign ex_stall               = skid_valid;
  assign ex_valid               = out_q.valid;
  assign ex_strand              = out_q.strand;
  assign ex_pc                  = out_q.pc;
  assign ex_instruction         = out_q.instruction;
  assign ex_has_writeback       = out_q.has_writeback;
  assign ex_writeback_is_vector = out_q.writeback_is_vector;
  assign ex_writeback_reg       = out_q.writeback_reg;
  assign ex_mask                = out_q.mask;
  assign ex_result              = res_q;

`ifdef EX_MERGE_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_collision_count <= '0;
      perf_stall_cycles    <= '0;
    end else begin
      if (capture && (perf_collision_count != 32'hFFFF_FFFF))
        perf_collision_count <= perf_collision_count + 32'd1;
      if (skid_valid && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_issue_while_stalled: assert property (@(posedge clk) disable iff (!reset_n)
    ex_stall |-> !(sc_valid || mc_issue_valid))
    else $error("sc/mc input presented while ex_stall");
`endif

endmodule
